// File: rtl/var_state_bank_if.sv
// Engine-side bundle for var_state_bank: strobes, request vectors and results.
// The master drives requests; the slave (the bank) returns state and flags.
interface var_state_bank_if #(
    parameter int NUM_VARS = 16,
    parameter int LVL_W    = 10
);
    localparam int ST_W  = LVL_W + 3;
    localparam int IDX_W = $clog2(NUM_VARS);

    logic [2*NUM_VARS-1:0]    var_value_i;
    logic [2*NUM_VARS-1:0]    var_value_o;
    logic                     valid_from_decision_i;
    logic [IDX_W-1:0]         dec_var_i;
    logic                     dec_val_i;
    logic [LVL_W-1:0]         cur_level_i;
    logic                     apply_imply_i;
    logic                     find_imply_o;
    logic                     find_conflict_o;
    logic                     apply_analyze_i;
    logic [LVL_W-1:0]         max_level_o;
    logic                     analyze_done_o;
    logic                     apply_bkt_i;
    logic [LVL_W-1:0]         bkt_lvl_i;
    logic                     wr_states_i;
    logic [ST_W*NUM_VARS-1:0] vars_states_i;
    logic [ST_W*NUM_VARS-1:0] vars_states_o;
    logic                     busy_o;
    logic                     op_err_o;

    modport master (
        output var_value_i, valid_from_decision_i, dec_var_i, dec_val_i, cur_level_i,
               apply_imply_i, apply_analyze_i, apply_bkt_i, bkt_lvl_i, wr_states_i,
               vars_states_i,
        input  var_value_o, find_imply_o, find_conflict_o, max_level_o, analyze_done_o,
               vars_states_o, busy_o, op_err_o
    );

    modport slave (
        input  var_value_i, valid_from_decision_i, dec_var_i, dec_val_i, cur_level_i,
               apply_imply_i, apply_analyze_i, apply_bkt_i, bkt_lvl_i, wr_states_i,
               vars_states_i,
        output var_value_o, find_imply_o, find_conflict_o, max_level_o, analyze_done_o,
               vars_states_o, busy_o, op_err_o
    );
endinterface

// File: rtl/var_state_bank.sv
// Variable-state store for the SAT engine: decide, imply, backtrack, bulk load,
// and a chunked multi-cycle max-level scan over a latched member mask.
module var_state_bank #(
    parameter int NUM_VARS = 16,
    parameter int LVL_W    = 10,
    parameter int CHUNK    = 4
) (
    input logic             clk,
    input logic             rst,
    var_state_bank_if.slave bus
);
    localparam int ST_W       = LVL_W + 3;
    localparam int NUM_CHUNKS = NUM_VARS / CHUNK;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ST_W-1:0]     st     [NUM_VARS];
    logic [ST_W-1:0]     imp_st [NUM_VARS];
    logic [NUM_VARS-1:0] member, mask;
    logic [LVL_W-1:0]    acc, acc_nxt, chunk_max, max_level;
    logic [CNT_W-1:0]    cnt;
    logic                busy, scan_en, done_set, last_chunk;
    logic                wr_go, bkt_go, ana_go, imp_go, dec_go, drop;
    logic [2:0]          n_strobes;
    logic                any_new, any_conf;
    logic                find_imply, find_conflict, analyze_done, op_err;

    assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = ana_go ? SCAN : IDLE;
            SCAN: begin
                if (bus.wr_states_i)  state_nxt = IDLE;
                else if (last_chunk)  state_nxt = DONE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == SCAN);
        scan_en  = busy && !bus.wr_states_i;
        done_set = scan_en && last_chunk;
    end

    // Fixed priority wr > bkt > analyze > imply > decide; a scan blocks all but wr.
    always_comb begin
        n_strobes = 3'(bus.wr_states_i) + 3'(bus.apply_bkt_i) + 3'(bus.apply_analyze_i)
                  + 3'(bus.apply_imply_i) + 3'(bus.valid_from_decision_i);
        wr_go  = bus.wr_states_i;
        bkt_go = !busy && !bus.wr_states_i && bus.apply_bkt_i;
        ana_go = !busy && !bus.wr_states_i && !bus.apply_bkt_i && bus.apply_analyze_i;
        imp_go = !busy && !bus.wr_states_i && !bus.apply_bkt_i && !bus.apply_analyze_i
               && bus.apply_imply_i;
        dec_go = !busy && !bus.wr_states_i && !bus.apply_bkt_i && !bus.apply_analyze_i
               && !bus.apply_imply_i && bus.valid_from_decision_i;
        drop   = (n_strobes > 3'd1)
               || (busy && (bus.apply_bkt_i || bus.apply_analyze_i || bus.apply_imply_i
                            || bus.valid_from_decision_i));
    end

    always_comb begin
        any_new  = 1'b0;
        any_conf = 1'b0;
        for (int unsigned i = 0; i < NUM_VARS; i++) begin
            imp_st[i] = st[i];
            member[i] = (bus.var_value_i[2*i +: 2] == 2'b11);
            if (bus.var_value_i[2*i +: 2] == 2'b01 || bus.var_value_i[2*i +: 2] == 2'b10) begin
                if (st[i][ST_W-1 -: 2] == 2'b00) begin
                    imp_st[i] = {bus.var_value_i[2*i +: 2], 1'b1, bus.cur_level_i};
                    any_new   = 1'b1;
                end else if (st[i][ST_W-1 -: 2] != bus.var_value_i[2*i +: 2]) begin
                    any_conf = 1'b1;
                end
            end
        end
    end

    always_comb begin
        chunk_max = '0;
        for (int unsigned i = 0; i < NUM_VARS; i++) begin
            if (CNT_W'(i / CHUNK) == cnt && mask[i] && st[i][ST_W-1 -: 2] != 2'b00
                && st[i][LVL_W-1:0] > chunk_max)
                chunk_max = st[i][LVL_W-1:0];
        end
        acc_nxt = (chunk_max > acc) ? chunk_max : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_VARS; i++) st[i] <= '0;
            find_imply    <= 1'b0;
            find_conflict <= 1'b0;
            analyze_done  <= 1'b0;
            max_level     <= '0;
            op_err        <= 1'b0;
            mask          <= '0;
            acc           <= '0;
            cnt           <= '0;
        end else begin
            find_imply    <= 1'b0;
            find_conflict <= 1'b0;
            analyze_done  <= done_set;
            if (done_set) max_level <= acc_nxt;
            if (drop)     op_err    <= 1'b1;

            if (wr_go) begin
                for (int unsigned i = 0; i < NUM_VARS; i++)
                    st[i] <= bus.vars_states_i[i*ST_W +: ST_W];
            end else if (bkt_go) begin
                for (int unsigned i = 0; i < NUM_VARS; i++)
                    if (st[i][LVL_W-1:0] > bus.bkt_lvl_i) st[i] <= '0;
            end else if (imp_go) begin
                for (int unsigned i = 0; i < NUM_VARS; i++) st[i] <= imp_st[i];
                find_imply    <= any_new;
                find_conflict <= any_conf;
            end else if (dec_go) begin
                st[bus.dec_var_i] <= {(bus.dec_val_i ? 2'b10 : 2'b01), 1'b0, bus.cur_level_i};
            end

            if (ana_go) begin
                mask <= member;
                acc  <= '0;
                cnt  <= '0;
            end else if (scan_en) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        bus.var_value_o   = '0;
        bus.vars_states_o = '0;
        for (int unsigned i = 0; i < NUM_VARS; i++) begin
            bus.var_value_o[2*i +: 2]        = st[i][ST_W-1 -: 2];
            bus.vars_states_o[i*ST_W +: ST_W] = st[i];
        end
    end

    assign bus.find_imply_o    = find_imply;
    assign bus.find_conflict_o = find_conflict;
    assign bus.max_level_o     = max_level;
    assign bus.analyze_done_o  = analyze_done;
    assign bus.busy_o          = busy;
    assign bus.op_err_o        = op_err;
endmodule
